// File: rtl/teller_call_dispatcher_pkg.sv
// Shared definitions for the teller call dispatcher: FSM states and common widths.
package teller_call_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_HOLD
  } disp_state_e;

  localparam int unsigned TICKET_MAX_DEF = 99;
  localparam int unsigned TELLER_IDX_W   = 2;

endpackage

// File: rtl/teller_call_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at/after ptr, wrapping.
module teller_call_dispatcher_rr_arbiter
  import teller_call_dispatcher_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [TELLER_IDX_W-1:0] ptr,
  output logic [N_REQ-1:0]        grant,
  output logic [TELLER_IDX_W-1:0] idx
);

  int unsigned             pos;
  logic [TELLER_IDX_W-1:0] pos_idx;
  logic                    found;

  // Scan requests starting at the pointer and take the first one found.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos     = (32'(ptr) + i) % N_REQ;
      pos_idx = TELLER_IDX_W'(pos);
      if (!found && req[pos_idx]) begin
        found          = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/teller_call_dispatcher.sv
// Teller call dispatcher: latches teller "next" requests, grants them round-robin,
// pulses the person-counter decrement and holds an announce window per call.
module teller_call_dispatcher
  import teller_call_dispatcher_pkg::*;
#(
  parameter int unsigned N_TELLERS   = 3,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TICKET_W    = 7,
  parameter int unsigned TICKET_MAX  = TICKET_MAX_DEF,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_TELLERS-1:0] next_req,
  input  logic [CNT_W-1:0]     queue_count,
  output logic                 call_dec,
  output logic [1:0]           called_teller,
  output logic [TICKET_W-1:0]  ticket_no,
  output logic                 call_active,
  output logic [N_TELLERS-1:0] pending
);

  localparam int unsigned       TIMER_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  disp_state_e state, state_nxt;

  logic [N_TELLERS-1:0]    sync1, sync2, sync3;
  logic [N_TELLERS-1:0]    edges;
  logic [N_TELLERS-1:0]    gnt_onehot;
  logic [N_TELLERS-1:0]    gnt_clr;
  logic [TELLER_IDX_W-1:0] gnt_idx;
  logic [TELLER_IDX_W-1:0] rr_ptr;
  logic [TIMER_W-1:0]      timer;

  assign edges   = sync2 & ~sync3;
  assign gnt_clr = (state == ST_GRANT) ? gnt_onehot : '0;

  teller_call_dispatcher_rr_arbiter #(
    .N_REQ (N_TELLERS)
  ) u_arb (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (gnt_onehot),
    .idx   (gnt_idx)
  );

  // Next-state logic: grant only from IDLE with work pending and people waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if ((pending != '0) && (queue_count != '0)) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_HOLD;
      ST_HOLD:  if (timer == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register plus output flags registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      call_dec    <= 1'b0;
      call_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      call_dec    <= (state_nxt == ST_GRANT);
      call_active <= (state_nxt == ST_HOLD);
    end
  end

  // Synchroniser, pending latch (a new edge wins over the grant clear), call bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1         <= '0;
      sync2         <= '0;
      sync3         <= '0;
      pending       <= '0;
      called_teller <= '0;
      ticket_no     <= '0;
      rr_ptr        <= '0;
      timer         <= '0;
    end else begin
      sync1   <= next_req;
      sync2   <= sync1;
      sync3   <= sync2;
      pending <= (pending & ~gnt_clr) | edges;
      if (state == ST_GRANT) begin
        called_teller <= gnt_idx + 2'd1;
        ticket_no     <= (ticket_no == TICKET_W'(TICKET_MAX)) ? '0 : ticket_no + TICKET_W'(1);
        rr_ptr        <= (gnt_idx == TELLER_IDX_W'(N_TELLERS - 1)) ? '0 : gnt_idx + 2'd1;
        timer         <= TIMER_LOAD;
      end else if ((state == ST_HOLD) && (timer != '0)) begin
        timer <= timer - TIMER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_teller_call_dispatcher.sv
// Randomised and directed bench for teller_call_dispatcher against a timing-level model.
module tb_teller_call_dispatcher;

  localparam int N    = 3;
  localparam int H    = 4;
  localparam int TMAX = 99;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] next_req;
  logic [3:0] queue_count;
  logic       call_dec;
  logic [1:0] called_teller;
  logic [6:0] ticket_no;
  logic       call_active;
  logic [2:0] pending;

  always #5 clk = ~clk;

  teller_call_dispatcher #(
    .N_TELLERS   (3),
    .CNT_W       (4),
    .TICKET_W    (7),
    .TICKET_MAX  (99),
    .HOLD_CYCLES (H)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .next_req      (next_req),
    .queue_count   (queue_count),
    .call_dec      (call_dec),
    .called_teller (called_teller),
    .ticket_no     (ticket_no),
    .call_active   (call_active),
    .pending       (pending)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: button history (raw samples), request set, call window.
  bit [2:0] m_pend, h1, h2, h3;
  int       m_rr, m_ticket, m_teller, m_hold;
  bit       m_grant;

  // Observation log: cycle of each call pulse, teller/ticket shown after it.
  int  cyc;
  int  pq[$];
  int  tq[$];
  int  kq[$];
  bit  prev_dec;

  function automatic int getq(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; h1 = '0; h2 = '0; h3 = '0;
    m_rr = 0; m_ticket = 0; m_teller = 0; m_hold = 0; m_grant = 1'b0;
  endtask

  task automatic clear_log();
    pq.delete(); tq.delete(); kq.delete();
    prev_dec = 1'b0;
  endtask

  // One clock edge worth of specification behaviour.
  task automatic model_edge();
    bit [2:0] e;
    int g;
    e = h2 & ~h3;
    if (m_grant) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (g < 0 && m_pend[k]) g = k;
      end
      if (g >= 0) begin
        m_pend[g] = 1'b0;
        m_teller  = g + 1;
        m_ticket  = (m_ticket == TMAX) ? 0 : m_ticket + 1;
        m_rr      = (g + 1) % N;
      end
      m_hold  = H;
      m_grant = 1'b0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_pend != 0 && queue_count != 0) begin
      m_grant = 1'b1;
    end
    m_pend = m_pend | e;
    h3 = h2; h2 = h1; h1 = next_req;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("call_dec",      call_dec,      m_grant);
    check("call_active",   call_active,   m_hold > 0);
    check("called_teller", called_teller, m_teller);
    check("ticket_no",     ticket_no,     m_ticket);
    check("pending",       pending,       m_pend);
    if (prev_dec) begin
      tq.push_back(called_teller);
      kq.push_back(ticket_no);
    end
    if (call_dec) pq.push_back(cyc);
    prev_dec = call_dec;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_call_dec",    call_dec,      0);
    check("rst_call_active", call_active,   0);
    check("rst_teller",      called_teller, 0);
    check("rst_ticket",      ticket_no,     0);
    check("rst_pending",     pending,       0);
    model_reset();
    clear_log();
    next_req = '0;
    @(posedge clk);
    #1;
    check("rst_hold_pending", pending, 0);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; next_req = '0; queue_count = '0; cyc = 0;
    model_reset();
    clear_log();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_call_dec", call_dec,      0);
    check("init_teller",   called_teller, 0);
    check("init_ticket",   ticket_no,     0);
    check("init_active",   call_active,   0);
    check("init_pending",  pending,       0);
    #2 reset = 1'b1;

    // Single call from teller 2.
    queue_count = 4'd5;
    next_req = 3'b010; step();
    next_req = 3'b000; step(); step();
    check("single_pend",   pending,  3'b010);
    check("single_nodec",  call_dec, 0);
    repeat (12) step();
    check("single_calls",  pq.size(),   1);
    check("single_teller", getq(tq, 0), 2);
    check("single_ticket", getq(kq, 0), 1);
    check("single_clear",  pending,     0);

    // Round-robin from a fresh reset, all buttons together.
    do_reset();
    queue_count = 4'd9;
    next_req = 3'b111; step();
    next_req = 3'b000;
    repeat (25) step();
    check("rr_calls", pq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("rr_teller", getq(tq, i), i + 1);
      check("rr_ticket", getq(kq, i), i + 1);
    end
    check("rr_gap1", getq(pq, 1) - getq(pq, 0), H + 2);
    check("rr_gap2", getq(pq, 2) - getq(pq, 1), H + 2);

    // Empty queue keeps the request latched until someone is waiting.
    do_reset();
    queue_count = 4'd0;
    next_req = 3'b001; step();
    next_req = 3'b000;
    repeat (10) step();
    check("empty_pend",  pending,   3'b001);
    check("empty_nodec", pq.size(), 0);
    queue_count = 4'd1;
    step(); step();
    check("empty_dec",    pq.size(), 1);
    step();
    check("empty_teller", getq(tq, 0), 1);

    // Held button gives one call; re-press landing on the grant cycle gives another.
    do_reset();
    queue_count = 4'd3;
    next_req = 3'b100;
    repeat (20) step();
    next_req = 3'b000;
    repeat (10) step();
    check("held_calls",  pq.size(),   1);
    check("held_teller", getq(tq, 0), 3);
    clear_log();
    next_req = 3'b100; step();
    next_req = 3'b000; step();
    next_req = 3'b100; step();
    next_req = 3'b000;
    repeat (20) step();
    check("repress_calls", pq.size(),   2);
    check("repress_t0",    getq(tq, 0), 3);
    check("repress_t1",    getq(tq, 1), 3);
    check("repress_gap",   getq(pq, 1) - getq(pq, 0), H + 2);

    // Ticket wrap after 99.
    do_reset();
    queue_count = 4'd15;
    for (int s = 0; s < 1000 && pq.size() < 100; s++) begin
      next_req = (s % 2 == 0) ? 3'b111 : 3'b000;
      step();
    end
    next_req = 3'b000;
    repeat (2) step();
    check("wrap_calls",  pq.size() >= 100, 1);
    check("wrap_99",     getq(kq, 98), 99);
    check("wrap_0",      getq(kq, 99), 0);

    // Random traffic with occasional resets.
    do_reset();
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 3) == 0) next_req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        queue_count = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
